bitmap_addr_stream: RTL and testbench

BITMAP_ADDR_STREAM -- requirements
Module: bitmap_addr_stream

---
 rtl/bitmap_pkg.sv | 10 +
 rtl/bitmap_addr_stream_if.sv | 30 +++
 rtl/bitmap_wrap_axis.sv | 43 ++++
 rtl/bitmap_addr_stream.sv | 117 +++++++++++
 tb/tb_bitmap_addr_stream.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/bitmap_pkg.sv
// Shared constants for the bitmap address stream: mode encoding and default widths.
package bitmap_pkg;

  localparam int CORDW_DEF = 16;
  localparam int ADDRW_DEF = 24;

  localparam logic MODE_CLIP = 1'b0;
  localparam logic MODE_WRAP = 1'b1;

endpackage

// File: rtl/bitmap_addr_stream_if.sv
// Request/result handshake bundle for bitmap_addr_stream; master = requester, slave = address unit.
interface bitmap_addr_stream_if #(
  parameter int CORDW = bitmap_pkg::CORDW_DEF,
  parameter int ADDRW = bitmap_pkg::ADDRW_DEF
);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [CORDW-1:0] x;
  logic signed [CORDW-1:0] y;
  logic signed [CORDW-1:0] offx;
  logic signed [CORDW-1:0] offy;
  logic                    wrap;

  logic                    out_valid;
  logic                    out_ready;
  logic [ADDRW-1:0]        addr;
  logic                    clip;

  modport master (
    output in_valid, x, y, offx, offy, wrap, out_ready,
    input  in_ready, out_valid, addr, clip
  );

  modport slave (
    input  in_valid, x, y, offx, offy, wrap, out_ready,
    output in_ready, out_valid, addr, clip
  );

endinterface

// File: rtl/bitmap_wrap_axis.sv
// One-axis range check with optional single-step wrap correction.
// Wrap correction exists only when BITMAP_ADDR_WRAP_EN is defined; otherwise clip-only.
module bitmap_wrap_axis
  import bitmap_pkg::*;
#(
  parameter int CORDW = CORDW_DEF
) (
  input  logic signed [CORDW:0]   s,
  input  logic signed [CORDW-1:0] dim,
  input  logic                    mode,
  output logic [CORDW-1:0]        coord,
  output logic                    out_of_range
);

  // Two guard bits so that s+dim, s-dim and 2*dim never overflow.
  logic signed [CORDW+1:0] s_e;
  logic signed [CORDW+1:0] dim_e;
  logic signed [CORDW+1:0] c;

  assign s_e   = {s[CORDW], s};
  assign dim_e = {{2{dim[CORDW-1]}}, dim};

`ifdef BITMAP_ADDR_WRAP_EN
  always_comb begin
    c = s_e;
    if (mode == MODE_WRAP) begin
      if (s_e[CORDW+1] && (s_e >= -dim_e)) begin
        c = s_e + dim_e;
      end else if ((s_e >= dim_e) && (s_e < (dim_e <<< 1))) begin
        c = s_e - dim_e;
      end
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign c = s_e;
`endif

  assign out_of_range = dim[CORDW-1] || (dim == '0) || c[CORDW+1] || (c >= dim_e);
  assign coord        = c[CORDW-1:0];

endmodule

// File: rtl/bitmap_addr_stream.sv
// Pixel coordinate to memory address pipeline: offset sum, wrap/clip, multiply, add.
// Optional wrap-around mode is built only with BITMAP_ADDR_WRAP_EN defined.
module bitmap_addr_stream
  import bitmap_pkg::*;
#(
  parameter int CORDW = CORDW_DEF,
  parameter int ADDRW = ADDRW_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [CORDW-1:0] bmpw,
  input  logic signed [CORDW-1:0] bmph,
  input  logic [ADDRW-1:0]        base,
  bitmap_addr_stream_if.slave     bus
);

  logic adv;

  logic                  s1_valid;
  logic signed [CORDW:0] s1_sx;
  logic signed [CORDW:0] s1_sy;
  logic                  s1_mode;

  logic             s2_valid;
  logic             s2_clip;
  logic [CORDW-1:0] s2_wx;
  logic [CORDW-1:0] s2_wy;

  logic             s3_valid;
  logic             s3_clip;
  logic [ADDRW-1:0] s3_mul;
  logic [ADDRW-1:0] s3_wx;

  logic [CORDW-1:0] wx;
  logic [CORDW-1:0] wy;
  logic             oor_x;
  logic             oor_y;

  logic [ADDRW-1:0] bmpw_a;
  logic [ADDRW-1:0] wy_a;

  // Whole pipeline moves in lockstep; a stalled output freezes every stage.
  assign adv         = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv || rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= bus.in_valid;
    end
    if (adv) begin
      s1_sx   <= {bus.x[CORDW-1], bus.x} + {bus.offx[CORDW-1], bus.offx};
      s1_sy   <= {bus.y[CORDW-1], bus.y} + {bus.offy[CORDW-1], bus.offy};
      s1_mode <= bus.wrap;
    end
  end

  bitmap_wrap_axis #(.CORDW(CORDW)) u_axis_x (
    .s            (s1_sx),
    .dim          (bmpw),
    .mode         (s1_mode),
    .coord        (wx),
    .out_of_range (oor_x)
  );

  bitmap_wrap_axis #(.CORDW(CORDW)) u_axis_y (
    .s            (s1_sy),
    .dim          (bmph),
    .mode         (s1_mode),
    .coord        (wy),
    .out_of_range (oor_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (adv) begin
      s2_valid <= s1_valid;
    end
    if (adv) begin
      s2_clip <= oor_x || oor_y;
      s2_wx   <= wx;
      s2_wy   <= wy;
    end
  end

  // Product is taken modulo 2^ADDRW, so the operands can be truncated first.
  assign bmpw_a = ADDRW'($unsigned(bmpw));
  assign wy_a   = ADDRW'(s2_wy);

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid <= 1'b0;
    end else if (adv) begin
      s3_valid <= s2_valid;
    end
    if (adv) begin
      s3_clip <= s2_clip;
      s3_mul  <= bmpw_a * wy_a;
      s3_wx   <= ADDRW'(s2_wx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.clip      <= 1'b0;
      bus.addr      <= '0;
    end else if (adv) begin
      bus.out_valid <= s3_valid;
      bus.clip      <= s3_clip;
      bus.addr      <= s3_clip ? base : (base + s3_mul + s3_wx);
    end
  end

endmodule

// File: tb/tb_bitmap_addr_stream.sv
// Directed self-checking bench for bitmap_addr_stream; wrap expectations follow BITMAP_ADDR_WRAP_EN.
module tb_bitmap_addr_stream;
  import bitmap_pkg::*;

  localparam int CORDW = 16;
  localparam int ADDRW = 24;

  logic                    clk = 1'b0;
  logic                    rst;
  logic signed [CORDW-1:0] bmpw;
  logic signed [CORDW-1:0] bmph;
  logic [ADDRW-1:0]        base;

  int total = 0;
  int bad   = 0;

  bitmap_addr_stream_if #(.CORDW(CORDW), .ADDRW(ADDRW)) bus ();

  bitmap_addr_stream #(.CORDW(CORDW), .ADDRW(ADDRW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bmpw (bmpw),
    .bmph (bmph),
    .base (base),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request and returns just after the accepting edge.
  task automatic applyStimulus(input int xi, input int yi, input int oxi, input int oyi, input logic w);
    bus.x         = CORDW'(xi);
    bus.y         = CORDW'(yi);
    bus.offx      = CORDW'(oxi);
    bus.offy      = CORDW'(oyi);
    bus.wrap      = w;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    #1;
    if (!bus.in_ready) chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  // Counts edges after acceptance until out_valid, then checks latency and result.
  task automatic checkOutput(input string tag, input logic [ADDRW-1:0] ea, input logic ec);
    int n;
    n = 0;
    while (!bus.out_valid && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd3);
    chk({tag, "_addr"}, 32'(bus.addr), 32'(ea));
    chk({tag, "_clip"}, 32'(bus.clip), 32'(ec));
    step();
  endtask

  logic [ADDRW-1:0] bp_exp [8] = '{24'd4096, 24'd4419, 24'd4742, 24'd5065,
                                   24'd5388, 24'd5711, 24'd6034, 24'd6357};

  initial begin
    int sent;
    int got;
    int cyc;
    logic stale;

    rst           = 1'b1;
    bmpw          = 16'sd320;
    bmph          = 16'sd240;
    base          = 24'h001000;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.x         = '0;
    bus.y         = '0;
    bus.offx      = '0;
    bus.offy      = '0;
    bus.wrap      = MODE_CLIP;

    step();
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    rst = 1'b0;
    #1;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_addr", 32'(bus.addr), 32'd0);
    chk("reset_clip", 32'(bus.clip), 32'd0);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
    step();

    applyStimulus(10, 2, 0, 0, MODE_CLIP);
    checkOutput("basic", 24'h00128A, 1'b0);

    applyStimulus(320, 2, 0, 0, MODE_CLIP);
    checkOutput("clip_x_eq_w", 24'h001000, 1'b1);

    applyStimulus(319, 239, 0, 0, MODE_CLIP);
    checkOutput("corner", 24'd80895, 1'b0);

    applyStimulus(10, 2, -11, 0, MODE_CLIP);
    checkOutput("clip_neg_off", 24'h001000, 1'b1);

    applyStimulus(5, 240, 0, 0, MODE_CLIP);
    checkOutput("clip_y_eq_h", 24'h001000, 1'b1);

    applyStimulus(4, 3, 1, -1, MODE_CLIP);
    checkOutput("offset_both", 24'd4741, 1'b0);

    bmpw = 16'sd0;
    applyStimulus(0, 0, 0, 0, MODE_CLIP);
    checkOutput("zero_width", 24'h001000, 1'b1);
    bmpw = 16'sd320;
    bmph = -16'sd5;
    applyStimulus(0, 0, 0, 0, MODE_WRAP);
    checkOutput("neg_height", 24'h001000, 1'b1);
    bmph = 16'sd240;

    base = 24'h000000;
    applyStimulus(-1, 240, 0, 0, MODE_WRAP);
`ifdef BITMAP_ADDR_WRAP_EN
    checkOutput("wrap_neg", 24'd319, 1'b0);
`else
    checkOutput("wrap_neg", 24'd0, 1'b1);
`endif
    applyStimulus(700, 0, 0, 0, MODE_WRAP);
    checkOutput("wrap_far", 24'd0, 1'b1);
    applyStimulus(-1, 240, 0, 0, MODE_CLIP);
    checkOutput("clip_mode_neg", 24'd0, 1'b1);

    base = 24'h001000;
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 8 && cyc < 200) begin
      bus.out_ready = ((cyc % 3) == 0);
      if (sent < 8) begin
        bus.in_valid = 1'b1;
        bus.x        = CORDW'(3 * sent);
        bus.y        = CORDW'(sent);
        bus.offx     = '0;
        bus.offy     = '0;
        bus.wrap     = MODE_CLIP;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      chk("bp_in_ready", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
      if (bus.out_valid && bus.out_ready) begin
        chk("bp_addr", 32'(bus.addr), 32'(bp_exp[got]));
        chk("bp_clip", 32'(bus.clip), 32'd0);
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      step();
      cyc++;
    end
    chk("bp_count", 32'(got), 32'd8);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("bp_drain", 32'(bus.out_valid), 32'd0);

    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.x        = CORDW'(i);
      bus.y        = '0;
      step();
    end
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    rst = 1'b0;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_addr", 32'(bus.addr), 32'd0);
    stale = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.out_valid) stale = 1'b1;
      step();
    end
    chk("rst_no_stale", 32'(stale), 32'd0);

    applyStimulus(5, 1, 0, 0, MODE_CLIP);
    checkOutput("post_reset", 24'h001145, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
